load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 51 +++++
 rtl/load_store_unit_align.sv | 37 +++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared dbus types, LSU state encoding and RISC-V load/store funct3 codes.
// Pure declarations; no timing or backpressure of its own.
package load_store_unit_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        msize_t     size;
        logic [7:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store strobe/data placement and load extraction with sign/zero extension.
// Purely combinational, zero latency; no backpressure.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [2:0] offset,
    input  logic       is_store,
    input  word_t      wdata,
    input  word_t      bus_rdata,
    output logic [7:0] strobe,
    output word_t      store_data,
    output word_t      load_data
);

    logic [5:0] shamt;
    word_t      shifted;

    assign shamt = {offset, 3'b000};

    always_comb begin
        strobe     = is_store ? (size_mask(funct3[1:0]) << offset) : 8'h00;
        store_data = wdata << shamt;
        shifted    = bus_rdata >> shamt;
        // funct3[2] selects zero extension (the unsigned load variants)
        case (funct3[1:0])
            2'd0:    load_data = funct3[2] ? {56'b0, shifted[7:0]}
                                           : {{56{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = funct3[2] ? {48'b0, shifted[15:0]}
                                           : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = funct3[2] ? {32'b0, shifted[31:0]}
                                           : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage dbus engine: issues one aligned request per slot, captures the extended load result.
// Latency >= 2 cycles per access; holds ok low until data_ok, then holds the result until enable.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            op_valid,
    input  logic            op_load,
    input  logic            op_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output logic [XLEN-1:0] rdata,
    output logic            misalign,
    output logic            ok
);

    if (XLEN != 64) begin : g_xlen_check
        $error("load_store_unit supports only XLEN=64");
    end

    lsu_state_t state;
    lsu_state_t state_nxt;
    word_t      result_q;
    word_t      load_data;
    word_t      store_data;
    logic [7:0] strobe;
    logic       mem_op;
    logic       misaligned;
    logic       issue;
    logic       capture;
    logic       unused_addr_ok;

    assign unused_addr_ok = dresp.addr_ok;

    assign mem_op = op_valid & (op_load | op_store);

    always_comb begin
        case (funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
        misaligned = misaligned & mem_op;
    end

    assign issue = (state == LSU_IDLE) & mem_op & ~misaligned;

    lsu_align u_align (
        .funct3     (funct3),
        .offset     (addr[2:0]),
        .is_store   (op_store),
        .wdata      (wdata),
        .bus_rdata  (dresp.data),
        .strobe     (strobe),
        .store_data (store_data),
        .load_data  (load_data)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (issue) begin
                    capture   = dresp.data_ok;
                    state_nxt = dresp.data_ok ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dresp.data_ok) begin
                    capture   = 1'b1;
                    state_nxt = LSU_DONE;
                end
            end
            LSU_DONE: begin
                // stay put while stalled so the request is never re-issued
                if (enable) state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LSU_IDLE;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture) result_q <= op_load ? load_data : '0;
        end
    end

    assign dreq.valid  = ~rst & (issue | (state == LSU_WAIT));
    assign dreq.addr   = addr;
    assign dreq.size   = msize_t'(funct3[1:0]);
    assign dreq.strobe = strobe;
    assign dreq.data   = store_data;

    assign rdata    = result_q;
    assign misalign = ~rst & (state == LSU_IDLE) & misaligned;
    assign ok       = ((state == LSU_IDLE) & ~issue) | (state == LSU_DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency-programmable bus responder plus a result scoreboard.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        op_valid;
    logic        op_load;
    logic        op_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic [63:0] rdata;
    logic        misalign;
    logic        ok;

    int          checks = 0;
    int          errors = 0;
    int          bus_lat = 0;
    logic [63:0] bus_data = '0;
    int          bus_cnt = 0;
    int          vld_cycles = 0;
    int          vld_base;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .op_valid (op_valid),
        .op_load  (op_load),
        .op_store (op_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .dreq     (dreq),
        .dresp    (dresp),
        .rdata    (rdata),
        .misalign (misalign),
        .ok       (ok)
    );

    // bus responder: data_ok once the request has been held bus_lat cycles
    assign dresp.addr_ok = dreq.valid;
    assign dresp.data_ok = dreq.valid && (bus_cnt >= bus_lat);
    assign dresp.data    = bus_data;

    always @(posedge clk) begin
        if (rst || !dreq.valid || dresp.data_ok) bus_cnt <= 0;
        else                                     bus_cnt <= bus_cnt + 1;
    end

    always @(negedge clk) if (dreq.valid) vld_cycles <= vld_cycles + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] bdata, input int lat);
        op_valid = 1'b1;
        op_load  = ld;
        op_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        bus_data = bdata;
        bus_lat  = lat;
        vld_base = vld_cycles;
    endtask

    task automatic wait_done(input string tag);
        logic        got;
        logic [63:0] exp;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ok) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, {63'b0, got}, 64'd1);
        if (got && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_rdata"}, rdata, exp);
        end
    endtask

    task automatic advance();
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        op_valid = 1'b0;
        op_load  = 1'b0;
        op_store = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'b0, dreq.valid}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_misalign", {63'b0, misalign}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ok", {63'b0, ok}, 64'd1);
        @(posedge clk); #1;

        // ld, bus responds after 3 extra cycles
        set_op(1'b1, 1'b0, F3_LD, 64'h80001000, '0, 64'h1122334455667788, 3);
        exp_q.push_back(64'h1122334455667788);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ld_valid", {63'b0, dreq.valid}, 64'd1);
            chk("ld_ok", {63'b0, ok}, 64'd0);
            chk("ld_addr", dreq.addr, 64'h80001000);
            chk("ld_size", {62'b0, dreq.size}, 64'd3);
            chk("ld_strobe", {56'b0, dreq.strobe}, 64'd0);
        end
        wait_done("ld");
        chk("ld_vld_cycles", 64'(vld_cycles - vld_base), 64'd4);
        advance();

        set_op(1'b1, 1'b0, F3_LB, 64'h80000003, '0, 64'h0000000080000000, 0);
        exp_q.push_back(64'hFFFFFFFFFFFFFF80);
        wait_done("lb");
        advance();

        set_op(1'b1, 1'b0, F3_LBU, 64'h80000003, '0, 64'h0000000080000000, 0);
        exp_q.push_back(64'h0000000000000080);
        wait_done("lbu");
        advance();

        set_op(1'b1, 1'b0, F3_LH, 64'h80000004, '0, 64'h0000800100000000, 1);
        exp_q.push_back(64'hFFFFFFFFFFFF8001);
        wait_done("lh");
        advance();

        set_op(1'b1, 1'b0, F3_LWU, 64'h80000004, '0, 64'hF000000012345678, 2);
        exp_q.push_back(64'h00000000F0000000);
        wait_done("lwu");
        advance();

        set_op(1'b1, 1'b0, F3_LW, 64'h80000000, '0, 64'h00000000876543AB, 1);
        exp_q.push_back(64'hFFFFFFFF876543AB);
        wait_done("lw");
        advance();

        // sh into the top halfword
        set_op(1'b0, 1'b1, 3'b001, 64'h80000006, 64'h000000000000BEEF, 64'hFFFFFFFFFFFFFFFF, 1);
        exp_q.push_back(64'd0);
        @(negedge clk);
        chk("sh_valid", {63'b0, dreq.valid}, 64'd1);
        chk("sh_strobe", {56'b0, dreq.strobe}, 64'h00000000000000C0);
        chk("sh_data", dreq.data, 64'hBEEF000000000000);
        wait_done("sh");
        advance();

        // misaligned lw: no bus traffic, stage does not stall
        set_op(1'b1, 1'b0, F3_LW, 64'h80000002, '0, '0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mis_flag", {63'b0, misalign}, 64'd1);
            chk("mis_ok", {63'b0, ok}, 64'd1);
            chk("mis_valid", {63'b0, dreq.valid}, 64'd0);
            if (k < 2) begin @(posedge clk); #1; end
        end
        chk("mis_vld_cycles", 64'(vld_cycles - vld_base), 64'd0);
        advance();

        // load completes, then the pipeline stalls for 5 cycles
        set_op(1'b1, 1'b0, F3_LD, 64'h80000010, '0, 64'hCAFEF00DDEADBEEF, 1);
        exp_q.push_back(64'hCAFEF00DDEADBEEF);
        wait_done("stall_ld");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {63'b0, dreq.valid}, 64'd0);
            chk("stall_ok", {63'b0, ok}, 64'd1);
            chk("stall_rdata", rdata, 64'hCAFEF00DDEADBEEF);
        end
        chk("stall_vld_cycles", 64'(vld_cycles - vld_base), 64'd2);
        advance();
        @(negedge clk);
        chk("post_stall_ok", {63'b0, ok}, 64'd1);
        chk("post_stall_valid", {63'b0, dreq.valid}, 64'd0);
        @(posedge clk); #1;

        // reset while waiting on the bus
        set_op(1'b1, 1'b0, F3_LD, 64'h80000020, '0, 64'h0123456789ABCDEF, 10);
        @(negedge clk);
        chk("wrst_valid_idle", {63'b0, dreq.valid}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrst_valid_wait", {63'b0, dreq.valid}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        op_valid = 1'b0; op_load = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrst_valid", {63'b0, dreq.valid}, 64'd0);
        chk("wrst_rdata", rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrst_idle_ok", {63'b0, ok}, 64'd1);
        @(posedge clk); #1;

        // sd after reset proves the FSM restarted from idle
        set_op(1'b0, 1'b1, F3_LD, 64'h80000008, 64'hA5A5A5A55A5A5A5A, '0, 0);
        exp_q.push_back(64'd0);
        @(negedge clk);
        chk("sd_strobe", {56'b0, dreq.strobe}, 64'h00000000000000FF);
        chk("sd_data", dreq.data, 64'hA5A5A5A55A5A5A5A);
        wait_done("sd");
        advance();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
